// File: rtl/ahb_apb_cmd_bridge.sv
// rtl/ahb_apb_cmd_bridge.sv - AHB-Lite slave front end issuing one APB command per accepted transfer.
// Optional address range check: define AHB2APB_ADDR_CHECK_EN.
module ahb_apb_cmd_bridge #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int ADDR_LIMIT = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              hsel,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  output logic              hreadyout,
  output logic [DATA_W-1:0] hrdata,
  output logic              hresp,
  output logic              transfer,
  output logic              pwrite,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CAPT = 3'd1,
    S_XFER = 3'd2,
`ifdef AHB2APB_ADDR_CHECK_EN
    S_ERR1 = 3'd4,
    S_ERR2 = 3'd5,
`endif
    S_DONE = 3'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_hreadyout;
  logic                r_transfer;
  logic                r_pwrite;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_hrdata;
  logic                w_accept;
  logic                w_addr_ovf;
  logic                w_addr_bad;
  logic                w_next_err;

  assign w_accept   = hsel & htrans[1] & hready;
  assign w_addr_ovf = (haddr >= ADDR_W'(ADDR_LIMIT));

`ifdef AHB2APB_ADDR_CHECK_EN
  logic r_hresp;
  logic w_unused;
  assign w_unused   = htrans[0];
  assign w_addr_bad = w_addr_ovf;
  assign w_next_err = (w_next == S_ERR1) | (w_next == S_ERR2);
  assign hresp      = r_hresp;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) r_hresp <= 1'b0;
    else          r_hresp <= w_next_err;
  end
`else
  logic [1:0] w_unused;
  assign w_unused   = {htrans[0], w_addr_ovf};
  assign w_addr_bad = 1'b0;
  assign w_next_err = 1'b0;
  assign hresp      = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
`ifdef AHB2APB_ADDR_CHECK_EN
          w_next = w_addr_bad ? S_ERR1 : S_CAPT;
`else
          w_next = S_CAPT;
`endif
        end else begin
          w_next = S_IDLE;
        end
      end
      S_CAPT: w_next = S_XFER;
      S_XFER: if (pready) w_next = S_DONE;
`ifdef AHB2APB_ADDR_CHECK_EN
      S_ERR1: w_next = S_ERR2;
      S_ERR2: w_next = S_IDLE;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they change with the state itself.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state     <= S_IDLE;
      r_hreadyout <= 1'b1;
      r_transfer  <= 1'b0;
      r_pwrite    <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_hrdata    <= '0;
    end else begin
      r_state     <= w_next;
      r_hreadyout <= (w_next == S_IDLE) | (w_next == S_DONE) |
                     (w_next_err & (w_next != r_state) & (r_state != S_IDLE) & (r_state != S_DONE));
      r_transfer  <= (w_next == S_XFER);
      if (w_next == S_CAPT) begin
        r_addr   <= haddr;
        r_pwrite <= hwrite;
      end
      if ((r_state == S_CAPT) && r_pwrite)
        r_wdata <= hwdata;
      if ((r_state == S_XFER) && pready && !r_pwrite)
        r_hrdata <= prdata;
    end
  end

  assign hreadyout = r_hreadyout;
  assign transfer  = r_transfer;
  assign pwrite    = r_pwrite;
  assign addr      = r_addr;
  assign wdata     = r_wdata;
  assign hrdata    = r_hrdata;

endmodule
